fpu_op_sequencer: RTL
=====================

# fpu_op_sequencer

Registered, parametrised successor to the ALU's combinational opcode gating. Accepts one floating-point command per valid/ready handshake, validates and decodes the opcode, and drives a held one-hot `operation` vector to the IEEE754 datapath for a per-class, parameter-defined number of cycles. It then returns a response through a second valid/ready handshake. It sits between the instruction/command source and the FPU arithmetic units.

## Interface
Parameters:
- `OPCODE_W`, 5: opcode and `operation` width.
  - Bit 0 is the mode bit (add/sub select, compare polarity).
  - Bits `OPCODE_W-1:1` are one-hot op select.
- `LAT_ADD`, 3: execute cycles, op bit 1 (add/sub). Must be ≥1.
- `LAT_MUL`, 4: execute cycles, op bit 2.
- `LAT_DIV`, 12: execute cycles, op bit 3.
- `LAT_CMP`, 1: execute cycles, op bit 4.
- `CNT_W`, 4: latency counter width. Must be ≥ clog2(max LAT + 1).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_opcode`, in, `OPCODE_W`: command opcode.
- `operation`, out, `OPCODE_W`: registered datapath control, held during execute.
- `op_start`, out, 1: one-cycle pulse on the first execute cycle.
- `busy`, out, 1: state is not IDLE.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_error`, out, 1: command had an illegal opcode.
- `rsp_opcode`, out, `OPCODE_W`: opcode of the completed command.

## Operation
States: IDLE, EXEC, RESP.

IDLE:
- `cmd_ready`=1.
- On `cmd_valid && cmd_ready`, capture `cmd_opcode`.
- Legal opcode means exactly one bit set in `[OPCODE_W-1:1]`.
  - Legal: go to EXEC and load the counter with the matching LAT.
  - Illegal: go to RESP with error flag set. No EXEC, `operation` stays 0.

EXEC:
- `operation` = captured opcode, held constant.
- `op_start`=1 on the first EXEC cycle only.
- Counter decrements each cycle; at count 1, go to RESP.

RESP:
- `operation`=0, `rsp_valid`=1.
- `rsp_opcode` and `rsp_error` are held stable until `rsp_valid && rsp_ready`, then go to IDLE.

Opcode bits beyond bit 4 (when `OPCODE_W`>5) use `LAT_CMP`. Zero op-select bits is illegal.

## Timing
- Reset values (asserted the cycle after `rst` is sampled high):
  - state=IDLE.
  - `operation`=0, `op_start`=0, `busy`=0, `rsp_valid`=0, `rsp_error`=0, `rsp_opcode`=0, counter=0.
  - `cmd_ready` is forced 0 while `rst` is high.
- Accept at cycle T:
  - EXEC occupies T+1 … T+LAT.
  - `rsp_valid` rises at T+LAT+1.
- Illegal opcode accepted at T: `rsp_valid`=1, `rsp_error`=1 at T+1.
- Response handshake at cycle R: IDLE at R+1. Minimum command period is LAT+2 with `rsp_ready` tied high.
- `rsp_ready` low stalls in RESP indefinitely; `cmd_ready` stays 0 throughout.
- `cmd_valid` may drop without being accepted; no state change results.
- `rst` in EXEC or RESP aborts the command. No response is produced, and `operation` is 0 the next cycle.
- All outputs except `cmd_ready` are registered. `cmd_ready` is decoded from state and `rst` only.

## Configuration
- `FPU_SEQ_OPCOUNT_EN` defined:
  - Adds output port `op_count` [15:0].
  - It is a wrapping count of completed legal responses: it increments on a RESP handshake with `rsp_error`=0.
  - It is reset to 0 by `rst` and wraps 0xFFFF→0x0000.
- Not defined: no port, no counter logic. All other behaviour is identical.

## Structure
- Shared package `fpu_ctrl_pkg`:
  - State enum (IDLE/EXEC/RESP).
  - Op-bit index constants (`OP_MODE`=0, `OP_ADD`=1, `OP_MUL`=2, `OP_DIV`=3, `OP_CMP`=4).
  - Default latency constants.
- One sub-module: `fpu_op_decode`, combinational.
  - Inputs: opcode.
  - Outputs: legal flag and selected latency.
  - Reused by the future issue-queue block.

## Test plan
- Reset, then `cmd_opcode`=5'b00011 (sub) at T:
  - `op_start` at T+1.
  - `operation`=5'b00011 for T+1..T+3.
  - `rsp_valid` at T+4, `rsp_error`=0, `rsp_opcode`=5'b00011.
- `cmd_opcode`=5'b01000 (div) with `rsp_ready` low for 5 cycles after `rsp_valid`:
  - `operation` held for 12 cycles, then 0.
  - Response stays stable until the handshake.
  - `cmd_ready`=0 throughout.
- Illegal opcodes 5'b00110 and 5'b00001:
  - `rsp_valid`=1, `rsp_error`=1 at T+1.
  - `operation` never nonzero, no `op_start`.
- `rst` asserted on the 6th EXEC cycle of a div:
  - Next cycle all outputs are 0, state IDLE, no `rsp_valid` ever for that command.
  - Then `cmd_ready`=1 once `rst` is low.
- Back-to-back compares (5'b10000) with `cmd_valid` and `rsp_ready` tied high:
  - One accept every 3 cycles (LAT_CMP+2).
- With `FPU_SEQ_OPCOUNT_EN`:
  - 3 legal commands plus 1 illegal give `op_count`=3.
  - Preloading via 65536 legal responses wraps `op_count` to 0.

Source files
------------

// File: rtl/fpu_ctrl_pkg.sv
// Shared FPU control definitions: sequencer state encoding, op-bit indices and default latencies.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } fpu_state_e;

    localparam int unsigned OP_MODE = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_MUL  = 2;
    localparam int unsigned OP_DIV  = 3;
    localparam int unsigned OP_CMP  = 4;

    localparam int unsigned OPCODE_W_DEF = 5;
    localparam int unsigned LAT_ADD_DEF  = 3;
    localparam int unsigned LAT_MUL_DEF  = 4;
    localparam int unsigned LAT_DIV_DEF  = 12;
    localparam int unsigned LAT_CMP_DEF  = 1;
    localparam int unsigned CNT_W_DEF    = 4;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational opcode decode: legality (exactly one op-select bit) and execute latency.
// Takes only the op-select field; the mode bit never affects legality or latency.
module fpu_op_decode
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = OPCODE_W_DEF,
    parameter int unsigned LAT_ADD  = LAT_ADD_DEF,
    parameter int unsigned LAT_MUL  = LAT_MUL_DEF,
    parameter int unsigned LAT_DIV  = LAT_DIV_DEF,
    parameter int unsigned LAT_CMP  = LAT_CMP_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic [OPCODE_W-1:1] op_sel,
    output logic                legal,
    output logic [CNT_W-1:0]    latency
);

    // Compare and any op bit above it share the compare latency.
    always_comb begin
        legal   = $onehot(op_sel);
        latency = CNT_W'(LAT_CMP);
        if (op_sel[OP_ADD]) begin
            latency = CNT_W'(LAT_ADD);
        end else if (op_sel[OP_MUL]) begin
            latency = CNT_W'(LAT_MUL);
        end else if (op_sel[OP_DIV]) begin
            latency = CNT_W'(LAT_DIV);
        end
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// FPU op sequencer: accepts a command, holds a one-hot operation for its class latency, then responds.
// Optional FPU_SEQ_OPCOUNT_EN adds a wrapping 16-bit count of completed legal responses (op_count).
module fpu_op_sequencer
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = OPCODE_W_DEF,
    parameter int unsigned LAT_ADD  = LAT_ADD_DEF,
    parameter int unsigned LAT_MUL  = LAT_MUL_DEF,
    parameter int unsigned LAT_DIV  = LAT_DIV_DEF,
    parameter int unsigned LAT_CMP  = LAT_CMP_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OPCODE_W-1:0] cmd_opcode,
    output logic [OPCODE_W-1:0] operation,
    output logic                op_start,
    output logic                busy,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_error,
    output logic [OPCODE_W-1:0] rsp_opcode
`ifdef FPU_SEQ_OPCOUNT_EN
    ,
    output logic [15:0]         op_count
`endif
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_EXEC = ST_EXEC;
    localparam logic [1:0] S_RESP = ST_RESP;

    logic [1:0]          state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [OPCODE_W-1:0] operation_d;
    logic                op_start_d;
    logic                rsp_valid_d;
    logic                rsp_error_d;
    logic [OPCODE_W-1:0] rsp_opcode_d;
    logic                dec_legal;
    logic [CNT_W-1:0]    dec_latency;
`ifdef FPU_SEQ_OPCOUNT_EN
    logic [15:0]         op_count_d;
`endif

    fpu_op_decode #(
        .OPCODE_W (OPCODE_W),
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_CMP  (LAT_CMP),
        .CNT_W    (CNT_W)
    ) u_decode (
        .op_sel  (cmd_opcode[OPCODE_W-1:1]),
        .legal   (dec_legal),
        .latency (dec_latency)
    );

    // The only unregistered output: ready in IDLE unless reset is held.
    assign cmd_ready = (state == S_IDLE) && !rst;

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        operation_d  = operation;
        op_start_d   = 1'b0;
        rsp_valid_d  = rsp_valid;
        rsp_error_d  = rsp_error;
        rsp_opcode_d = rsp_opcode;
`ifdef FPU_SEQ_OPCOUNT_EN
        op_count_d   = op_count;
`endif
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (dec_legal) begin
                        state_d     = S_EXEC;
                        cnt_d       = dec_latency;
                        operation_d = cmd_opcode;
                        op_start_d  = 1'b1;
                    end else begin
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_error_d  = 1'b1;
                        rsp_opcode_d = cmd_opcode;
                    end
                end
            end
            S_EXEC: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_d      = S_RESP;
                    operation_d  = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_error_d  = 1'b0;
                    rsp_opcode_d = operation;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d      = S_IDLE;
                    rsp_valid_d  = 1'b0;
                    rsp_error_d  = 1'b0;
                    rsp_opcode_d = '0;
`ifdef FPU_SEQ_OPCOUNT_EN
                    if (!rsp_error) begin
                        op_count_d = op_count + 16'd1;
                    end
`endif
                end
            end
            default: begin
                state_d     = S_IDLE;
                operation_d = '0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            operation  <= '0;
            op_start   <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_error  <= 1'b0;
            rsp_opcode <= '0;
`ifdef FPU_SEQ_OPCOUNT_EN
            op_count   <= 16'd0;
`endif
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            operation  <= operation_d;
            op_start   <= op_start_d;
            busy       <= (state_d != S_IDLE);
            rsp_valid  <= rsp_valid_d;
            rsp_error  <= rsp_error_d;
            rsp_opcode <= rsp_opcode_d;
`ifdef FPU_SEQ_OPCOUNT_EN
            op_count   <= op_count_d;
`endif
        end
    end

endmodule
